// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch controller. It sequences the PC and keeps at most one
// like-SRAM request outstanding. Each instruction is buffered until decode
// takes it, and responses made stale by a redirect are dropped.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_adef,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [3:0]  inst_wstrb,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] inst_buf, inst_buf_nxt;
    logic        adef_buf, adef_buf_nxt;

    // A misaligned PC never reaches the bus; it turns into an ADEF handoff.
    logic misalign;
    logic req_en;
    assign misalign = |pc[1:0];
    assign req_en   = (state == S_REQ) && !misalign;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_RST;
        else         state <= state_nxt;
    end

    // PC and instruction buffer registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc       <= RESET_PC;
            inst_buf <= 32'h0;
            adef_buf <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            inst_buf <= inst_buf_nxt;
            adef_buf <= adef_buf_nxt;
        end
    end

    // Next-state and datapath updates. A redirect always wins over a bus event.
    // A handshake that coincides with a redirect still counts as outstanding
    // and has to be drained through DROP.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        inst_buf_nxt = inst_buf;
        adef_buf_nxt = adef_buf;
        case (state)
            S_RST: state_nxt = S_REQ;
            S_REQ: begin
                if (misalign) begin
                    if (redirect_valid) begin
                        pc_nxt = redirect_pc;
                    end else begin
                        inst_buf_nxt = 32'h0;
                        adef_buf_nxt = 1'b1;
                        state_nxt    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = inst_addr_ok ? S_DROP : S_REQ;
                end else if (inst_addr_ok) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = inst_data_ok ? S_REQ : S_DROP;
                end else if (inst_data_ok) begin
                    inst_buf_nxt = inst_rdata;
                    adef_buf_nxt = 1'b0;
                    state_nxt    = S_HOLD;
                end
            end
            S_DROP: begin
                if (redirect_valid) pc_nxt = redirect_pc;
                if (inst_data_ok)   state_nxt = S_REQ;
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = S_REQ;
                end else if (ds_allowin) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_RST;
        endcase
    end

    // Outputs are forced to zero while reset is held.
    assign inst_req       = resetn && req_en;
    assign inst_wr        = 1'b0;
    assign inst_size      = resetn ? 2'b10 : 2'b00;
    assign inst_wstrb     = 4'b0;
    assign inst_wdata     = 32'h0;
    assign inst_addr      = resetn ? pc : 32'h0;
    assign fs_pc          = resetn ? pc : 32'h0;
    assign fs_to_ds_valid = resetn && (state == S_HOLD);
    assign fs_inst        = fs_to_ds_valid ? inst_buf : 32'h0;
    assign fs_adef        = fs_to_ds_valid && adef_buf;

endmodule
